// File: rtl/bch_chien_ctrl.sv
// Purpose: Chien-search sequencer; drives the t-way root datapath, reads the buffered codeword, and flips located bits.
// Latency: locator at cycle 0 -> odp_load at 1 -> first oval at 2+DP_LAT -> oeop at block_n+1+DP_LAT.
// Backpressure: none downstream (oval contiguous); ordy=0 outside IDLE, and an iloc_poly_val then is dropped (odrop pulse).
//
// Ports: iclk/ireset (sync, active-high); iloc_poly_val/_deg/iloc_failed + ordy/odrop = locator handshake;
//        odp_load/odp_ena/idp_root = datapath strobes and root flag; oram_radr/oram_read/iram_rdat/oram_done = RAM port;
//        osop/oval/oeop/odat = corrected stream; odecfail/obiterr = block status, valid on oeop and held afterwards.
// Optional feature: BCH_CHIEN_ZERO_DEG_SKIP_EN -- a deg=0, non-failed locator idles the datapath and passes data through.
module bch_chien_ctrl #(
  parameter int m       = 4,
  parameter int t       = 2,
  parameter int block_n = 7,
  parameter int DP_LAT  = 2
) (
  input  logic         iclk,
  input  logic         ireset,
  input  logic         iloc_poly_val,
  input  logic [m-1:0] iloc_poly_deg,
  input  logic         iloc_failed,
  output logic         ordy,
  output logic         odrop,
  output logic         odp_load,
  output logic         odp_ena,
  input  logic         idp_root,
  output logic [m-1:0] oram_radr,
  output logic         oram_read,
  output logic         oram_done,
  input  logic         iram_rdat,
  output logic         osop,
  output logic         oval,
  output logic         oeop,
  output logic         odat,
  output logic         odecfail,
  output logic [m-1:0] obiterr
);

  localparam int DW = $clog2(DP_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEARCH, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [m-1:0]    pos_q, deg_q, root_cnt_q, cnt_next, biterr_q;
  logic            failed_q, decfail_q, drop_q;
  logic [DW-1:0]   drain_q;
  logic [DP_LAT-1:0] vld_sr, sop_sr, eop_sr;
  logic            search, last_pos, skip, root_eff, rdat_d;

  // The correction capability only bounds the locator degree upstream;
  // the sequencing here is independent of it.
  if (t < 1) begin : g_t_degenerate
  end

  assign search   = (state_q == S_SEARCH);
  assign last_pos = (pos_q == m'(block_n - 1));

`ifdef BCH_CHIEN_ZERO_DEG_SKIP_EN
  // A zero-degree locator that BM did not flag has no roots to find.
  assign skip = (deg_q == '0) && !failed_q;
`else
  assign skip = 1'b0;
`endif

  // State register
  always_ff @(posedge iclk) begin
    if (ireset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (iloc_poly_val) state_d = S_LOAD;
      S_LOAD:   state_d = S_SEARCH;
      S_SEARCH: if (last_pos) state_d = S_DRAIN;
      S_DRAIN:  if (drain_q == DW'(DP_LAT - 1)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ordy      = (state_q == S_IDLE);
    odp_load  = (state_q == S_LOAD) && !skip;
    odp_ena   = search && !skip;
    oram_read = search;
    oram_radr = search ? pos_q : '0;
  end

  // Counters, latched locator info and the alignment pipes
  always_ff @(posedge iclk) begin
    if (ireset) begin
      pos_q      <= '0;
      deg_q      <= '0;
      failed_q   <= 1'b0;
      drain_q    <= '0;
      root_cnt_q <= '0;
      biterr_q   <= '0;
      decfail_q  <= 1'b0;
      drop_q     <= 1'b0;
      vld_sr     <= '0;
      sop_sr     <= '0;
      eop_sr     <= '0;
    end else begin
      if ((state_q == S_IDLE) && iloc_poly_val) begin
        deg_q    <= iloc_poly_deg;
        failed_q <= iloc_failed;
      end
      drop_q <= iloc_poly_val && (state_q != S_IDLE);

      if (state_q == S_LOAD) pos_q <= '0;
      else if (search)       pos_q <= pos_q + 1'b1;

      if (search)                    drain_q <= '0;
      else if (state_q == S_DRAIN)   drain_q <= drain_q + 1'b1;

      if (state_q == S_LOAD) root_cnt_q <= '0;
      else                   root_cnt_q <= cnt_next;

      if (oeop) begin
        biterr_q  <= obiterr;
        decfail_q <= odecfail;
      end

      // Read strobe and framing marks travel DP_LAT cycles to meet idp_root.
      vld_sr[0] <= search;
      sop_sr[0] <= search && (pos_q == '0);
      eop_sr[0] <= search && last_pos;
      for (int i = 1; i < DP_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        sop_sr[i] <= sop_sr[i-1];
        eop_sr[i] <= eop_sr[i-1];
      end
    end
  end

  // RAM data already lags its read by one cycle, so it needs DP_LAT-1 more.
  if (DP_LAT == 1) begin : g_rdat_direct
    assign rdat_d = iram_rdat;
  end else begin : g_rdat_pipe
    logic [DP_LAT-2:0] rdat_sr;
    always_ff @(posedge iclk) begin
      if (ireset) begin
        rdat_sr <= '0;
      end else begin
        rdat_sr[0] <= iram_rdat;
        for (int i = 1; i < DP_LAT - 1; i++) rdat_sr[i] <= rdat_sr[i-1];
      end
    end
    assign rdat_d = rdat_sr[DP_LAT-2];
  end

  assign oval     = vld_sr[DP_LAT-1];
  assign osop     = sop_sr[DP_LAT-1];
  assign oeop     = eop_sr[DP_LAT-1];
  assign root_eff = idp_root && !skip;
  // Gate with oval so a stray root or RAM bit never leaks onto an idle bus.
  assign odat     = oval && (rdat_d ^ root_eff);

  // Saturating count that already includes the current beat, so the
  // status presented alongside oeop is final.
  assign cnt_next = (oval && root_eff && (root_cnt_q != '1)) ? root_cnt_q + 1'b1 : root_cnt_q;

  assign obiterr   = oeop ? cnt_next : biterr_q;
  assign odecfail  = oeop ? (failed_q || (cnt_next != deg_q)) : decfail_q;
  assign oram_done = oeop;
  assign odrop     = drop_q;

endmodule

// File: tb/tb_bch_chien_ctrl.sv
module tb_bch_chien_ctrl;

  localparam int M   = 4;
  localparam int BN  = 7;
  localparam int DPL = 2;

  logic         iclk = 1'b0;
  logic         ireset, iloc_poly_val, iloc_failed, idp_root, iram_rdat;
  logic [M-1:0] iloc_poly_deg;
  logic         ordy, odrop, odp_load, odp_ena, oram_read, oram_done;
  logic         osop, oval, oeop, odat, odecfail;
  logic [M-1:0] oram_radr, obiterr;

  always #5 iclk = ~iclk;

  bch_chien_ctrl #(.m(M), .t(2), .block_n(BN), .DP_LAT(DPL)) dut (
    .iclk(iclk), .ireset(ireset),
    .iloc_poly_val(iloc_poly_val), .iloc_poly_deg(iloc_poly_deg), .iloc_failed(iloc_failed),
    .ordy(ordy), .odrop(odrop), .odp_load(odp_load), .odp_ena(odp_ena), .idp_root(idp_root),
    .oram_radr(oram_radr), .oram_read(oram_read), .oram_done(oram_done), .iram_rdat(iram_rdat),
    .osop(osop), .oval(oval), .oeop(oeop), .odat(odat),
    .odecfail(odecfail), .obiterr(obiterr)
  );

  typedef struct {
    bit       dat;
    bit       sop;
    bit       eop;
    bit       fail;
    bit [3:0] bits;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;

  // RAM and datapath models
  logic [0:6] ram_m = '0;
  logic [0:6] mask_m = '0;
  bit         force_root = 1'b0;
  bit         samp_read, samp_ena;
  logic [3:0] samp_addr;
  bit         rp[DPL];

  always @(posedge iclk) cyc++;

  always @(negedge iclk) begin
    samp_read = oram_read;
    samp_ena  = odp_ena;
    samp_addr = oram_radr;
  end

  always @(posedge iclk) begin
    #1;
    iram_rdat = (samp_read && samp_addr < 7) ? ram_m[samp_addr] : 1'b0;
    for (int i = DPL - 1; i > 0; i--) rp[i] = rp[i-1];
    rp[0] = samp_ena && (samp_addr < 7) && mask_m[samp_addr];
    idp_root = force_root ? 1'b1 : rp[DPL-1];
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge iclk) begin
    if (oval === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat at cycle %0d: got oval=1, expected no beat", cyc);
      end else begin
        mon_b = exp_q.pop_front();
        chk("odat", odat, mon_b.dat);
        chk("osop", osop, mon_b.sop);
        chk("oeop", oeop, mon_b.eop);
        chk("oram_done", oram_done, mon_b.eop);
        if (mon_b.eop) begin
          chk("obiterr", obiterr, mon_b.bits);
          chk("odecfail", odecfail, mon_b.fail);
        end
      end
    end
  end

  task automatic tick();
    @(posedge iclk);
    #1;
    iloc_poly_val = 1'b0;
  endtask

  task automatic go(input int n);
    repeat (n) tick();
  endtask

  // Drive a locator this cycle and queue the expected beats.
  task automatic issue(input logic [3:0] deg, input bit fl, input logic [0:6] mask,
                       input logic [0:6] ram, input bit frc, input logic [0:6] edat,
                       input int nb, input int ebits, input bit efail);
    beat_t b;
    ram_m = ram;
    mask_m = mask;
    force_root = frc;
    for (int i = 0; i < nb; i++) begin
      b.dat  = edat[i];
      b.sop  = (i == 0);
      b.eop  = (i == BN - 1);
      b.bits = ebits[3:0];
      b.fail = efail;
      exp_q.push_back(b);
    end
    iloc_poly_deg = deg;
    iloc_failed   = fl;
    iloc_poly_val = 1'b1;
  endtask

  initial begin
    ireset = 1'b1; iloc_poly_val = 1'b0; iloc_poly_deg = '0; iloc_failed = 1'b0;
    idp_root = 1'b0; iram_rdat = 1'b0;
    go(3);
    ireset = 1'b0;
    tick();
    @(negedge iclk);
    chk("rst_ordy", ordy, 1);
    chk("rst_oval", oval, 0);
    chk("rst_odp_load", odp_load, 0);
    chk("rst_odrop", odrop, 0);
    chk("rst_obiterr", obiterr, 0);
    chk("rst_odecfail", odecfail, 0);

    // Block 1: roots at 1 and 5, RAM zero
    tick();
    issue(4'd2, 1'b0, 7'b0100010, 7'b0000000, 1'b0, 7'b0100010, 7, 2, 1'b0);
    tick(); @(negedge iclk);
    chk("b1_load", odp_load, 1);
    chk("b1_ordy_busy", ordy, 0);
    tick(); @(negedge iclk);
    chk("b1_ena", odp_ena, 1);
    chk("b1_read", oram_read, 1);
    chk("b1_radr0", oram_radr, 0);
    go(8); @(negedge iclk);
    chk("b1_eop_c10", oeop, 1);
    chk("b1_biterr", obiterr, 2);
    chk("b1_decfail", odecfail, 0);

    // Block 2 back-to-back: single root at 3
    tick();
    issue(4'd2, 1'b0, 7'b0001000, 7'b0000000, 1'b0, 7'b0001000, 7, 1, 1'b1);
    @(negedge iclk);
    chk("b2_ordy_c11", ordy, 1);
    go(10); @(negedge iclk);
    chk("b2_eop_c10", oeop, 1);
    tick(); @(negedge iclk);
    chk("b2_hold_biterr", obiterr, 1);
    chk("b2_hold_decfail", odecfail, 1);

    // Block 3: BM failed, one root, non-zero RAM
    issue(4'd1, 1'b1, 7'b0000010, 7'b1011001, 1'b0, 7'b1011011, 7, 1, 1'b1);
    go(10); @(negedge iclk);
    chk("b3_eop", oeop, 1);

    // Block 4: late locator dropped
    tick();
    issue(4'd1, 1'b0, 7'b0010000, 7'b0110100, 1'b0, 7'b0100100, 7, 1, 1'b0);
    go(4);
    iloc_poly_deg = 4'd3; iloc_failed = 1'b1; iloc_poly_val = 1'b1;
    tick(); @(negedge iclk);
    chk("b4_drop_c5", odrop, 1);
    tick(); @(negedge iclk);
    chk("b4_drop_c6", odrop, 0);
    go(4); @(negedge iclk);
    chk("b4_eop_c10", oeop, 1);
    chk("b4_ordy_c10", ordy, 0);
    tick(); @(negedge iclk);
    chk("b4_ordy_c11", ordy, 1);

    // Block 5: reset at cycle 5 aborts after two beats
    tick();
    issue(4'd2, 1'b0, 7'b1000001, 7'b0000000, 1'b0, 7'b1000001, 2, 2, 1'b0);
    go(5);
    ireset = 1'b1;
    tick();
    ireset = 1'b0;
    @(negedge iclk);
    chk("b5_ordy", ordy, 1);
    chk("b5_oval", oval, 0);
    chk("b5_oeop", oeop, 0);
    chk("b5_done", oram_done, 0);
    chk("b5_read", oram_read, 0);
    chk("b5_ena", odp_ena, 0);
    chk("b5_odat", odat, 0);
    chk("b5_biterr", obiterr, 0);
    chk("b5_decfail", odecfail, 0);
    tick();
    issue(4'd2, 1'b0, 7'b1000001, 7'b1111111, 1'b0, 7'b0111110, 7, 2, 1'b0);
    go(10); @(negedge iclk);
    chk("b5n_eop", oeop, 1);

    // Block 6: deg=0 with idp_root stuck high
    tick();
`ifdef BCH_CHIEN_ZERO_DEG_SKIP_EN
    issue(4'd0, 1'b0, 7'b0000000, 7'b0101010, 1'b1, 7'b0101010, 7, 0, 1'b0);
    tick(); @(negedge iclk);
    chk("b6_load", odp_load, 0);
    tick(); @(negedge iclk);
    chk("b6_ena", odp_ena, 0);
`else
    issue(4'd0, 1'b0, 7'b0000000, 7'b0101010, 1'b1, 7'b1010101, 7, 7, 1'b1);
    tick(); @(negedge iclk);
    chk("b6_load", odp_load, 1);
    tick(); @(negedge iclk);
    chk("b6_ena", odp_ena, 1);
`endif
    go(8); @(negedge iclk);
    chk("b6_eop", oeop, 1);
    force_root = 1'b0;
    go(4);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
